// File: rtl/neur_ctrl_pkg.sv
// Shared constants for the neuron sweep controller: FSM encoding, request types, spike entry width.
package neur_ctrl_pkg;

  typedef logic [1:0] ctrl_state_t;

  localparam ctrl_state_t ST_IDLE = 2'd0;
  localparam ctrl_state_t ST_RD   = 2'd1;
  localparam ctrl_state_t ST_WR   = 2'd2;

  localparam logic REQ_SINGLE = 1'b0;
  localparam logic REQ_SWEEP  = 1'b1;

  localparam int unsigned EVT_W   = 7;
  localparam int unsigned VIRTS_W = 5;

  // Spike entry is {neuron address, event code}
  function automatic int unsigned spk_width(input int unsigned m);
    return m + EVT_W;
  endfunction

endpackage

// File: rtl/spk_fifo.sv
// Synchronous first-word-fall-through FIFO for output spike entries.
// Head data reads as zero while empty so the output is defined after reset.
module spk_fifo #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/neur_sweep_ctrl.sv
// Neuron-core memory sequencer: read/write pair per neuron update, single or full sweep,
// spikes buffered in an FWFT FIFO. Define NEUR_SWEEP_DIS_SKIP_EN to skip rewriting disabled neurons.
module neur_sweep_ctrl
  import neur_ctrl_pkg::*;
#(
  parameter int unsigned N          = 256,
  parameter int unsigned M          = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                    CLK,
  input  logic                    RSTN_syncn,
  input  logic                    SPI_GATE_ACTIVITY_sync,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_TYPE,
  input  logic [M-1:0]            REQ_ADDR,
  input  logic [VIRTS_W-1:0]      REQ_VIRTS,
  output logic                    CTRL_NEURMEM_CS,
  output logic                    CTRL_NEURMEM_WE,
  output logic [M-1:0]            CTRL_NEURMEM_ADDR,
  output logic                    CTRL_NEUR_EVENT,
  output logic                    CTRL_NEUR_TREF,
  output logic [VIRTS_W-1:0]      CTRL_NEUR_VIRTS,
  input  logic [EVT_W-1:0]        NEUR_EVENT_OUT,
  input  logic                    NEUR_DISABLE,
  output logic                    SPK_VALID,
  input  logic                    SPK_READY,
  output logic [spk_width(M)-1:0] SPK_DATA,
  output logic                    SWEEP_BUSY
);

  localparam int unsigned SPK_W = spk_width(M);

  ctrl_state_t        state_q, state_d;
  logic               type_q, type_d;
  logic [M-1:0]       cur_addr_q, cur_addr_d;
  logic [VIRTS_W-1:0] virts_q, virts_d;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic [SPK_W-1:0]   fifo_push_data;
  logic               skip_wr;

`ifdef NEUR_SWEEP_DIS_SKIP_EN
  assign skip_wr = NEUR_DISABLE;
`else
  logic unused_disable;
  assign skip_wr        = 1'b0;
  assign unused_disable = NEUR_DISABLE;
`endif

  assign REQ_READY      = RSTN_syncn && (state_q == ST_IDLE) && !SPI_GATE_ACTIVITY_sync;
  assign SWEEP_BUSY     = RSTN_syncn && (state_q != ST_IDLE);
  assign fifo_push_data = {cur_addr_q, NEUR_EVENT_OUT};

  // Next state and memory-control decode; everything idles while reset is held.
  always_comb begin
    state_d           = state_q;
    type_d            = type_q;
    cur_addr_d        = cur_addr_q;
    virts_d           = virts_q;
    fifo_push         = 1'b0;
    CTRL_NEURMEM_CS   = 1'b0;
    CTRL_NEURMEM_WE   = 1'b0;
    CTRL_NEURMEM_ADDR = '0;
    CTRL_NEUR_EVENT   = 1'b0;
    CTRL_NEUR_TREF    = 1'b0;
    CTRL_NEUR_VIRTS   = '0;
    if (RSTN_syncn) begin
      case (state_q)
        ST_IDLE: begin
          if (REQ_VALID && REQ_READY) begin
            type_d     = REQ_TYPE;
            cur_addr_d = (REQ_TYPE == REQ_SWEEP) ? '0 : REQ_ADDR;
            virts_d    = (REQ_TYPE == REQ_SWEEP) ? '0 : REQ_VIRTS;
            state_d    = ST_RD;
          end
        end
        ST_RD: begin
          // A full FIFO stalls here so the following write can always push.
          if (!fifo_full) begin
            CTRL_NEURMEM_CS   = 1'b1;
            CTRL_NEURMEM_ADDR = cur_addr_q;
            state_d           = ST_WR;
          end
        end
        ST_WR: begin
          CTRL_NEURMEM_CS   = !skip_wr;
          CTRL_NEURMEM_WE   = !skip_wr;
          CTRL_NEURMEM_ADDR = cur_addr_q;
          CTRL_NEUR_EVENT   = (type_q == REQ_SINGLE);
          CTRL_NEUR_TREF    = (type_q == REQ_SWEEP);
          CTRL_NEUR_VIRTS   = virts_q;
          fifo_push         = !skip_wr && (NEUR_EVENT_OUT != '0);
          if ((type_q == REQ_SINGLE) || (cur_addr_q == M'(N - 1))) begin
            state_d = ST_IDLE;
          end else begin
            cur_addr_d = cur_addr_q + M'(1);
            state_d    = ST_RD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN_syncn) begin
      state_q    <= ST_IDLE;
      type_q     <= REQ_SINGLE;
      cur_addr_q <= '0;
      virts_q    <= '0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      cur_addr_q <= cur_addr_d;
      virts_q    <= virts_d;
    end
  end

  spk_fifo #(
    .WIDTH (SPK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_spk_fifo (
    .clk       (CLK),
    .rst_n     (RSTN_syncn),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (SPK_READY),
    .head_data (SPK_DATA),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign SPK_VALID = !fifo_empty;

endmodule

// File: tb/tb_neur_sweep_ctrl.sv
// Directed self-checking bench for neur_sweep_ctrl (N=256, FIFO_DEPTH=8).
// Stimulus drives and samples on the falling clock edge.
module tb_neur_sweep_ctrl;

  logic        CLK = 1'b0;
  logic        RSTN_syncn;
  logic        SPI_GATE_ACTIVITY_sync;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_TYPE;
  logic [7:0]  REQ_ADDR;
  logic [4:0]  REQ_VIRTS;
  logic        CTRL_NEURMEM_CS;
  logic        CTRL_NEURMEM_WE;
  logic [7:0]  CTRL_NEURMEM_ADDR;
  logic        CTRL_NEUR_EVENT;
  logic        CTRL_NEUR_TREF;
  logic [4:0]  CTRL_NEUR_VIRTS;
  logic [6:0]  NEUR_EVENT_OUT;
  logic        NEUR_DISABLE;
  logic        SPK_VALID;
  logic        SPK_READY;
  logic [14:0] SPK_DATA;
  logic        SWEEP_BUSY;

  logic [255:0] spk_mask;
  logic [6:0]   evt_code;
  logic         dis_en;
  logic [7:0]   dis_addr;

  int checks = 0;
  int errors = 0;

  neur_sweep_ctrl #(.N(256), .M(8), .FIFO_DEPTH(8)) dut (
    .CLK                    (CLK),
    .RSTN_syncn             (RSTN_syncn),
    .SPI_GATE_ACTIVITY_sync (SPI_GATE_ACTIVITY_sync),
    .REQ_VALID              (REQ_VALID),
    .REQ_READY              (REQ_READY),
    .REQ_TYPE               (REQ_TYPE),
    .REQ_ADDR               (REQ_ADDR),
    .REQ_VIRTS              (REQ_VIRTS),
    .CTRL_NEURMEM_CS        (CTRL_NEURMEM_CS),
    .CTRL_NEURMEM_WE        (CTRL_NEURMEM_WE),
    .CTRL_NEURMEM_ADDR      (CTRL_NEURMEM_ADDR),
    .CTRL_NEUR_EVENT        (CTRL_NEUR_EVENT),
    .CTRL_NEUR_TREF         (CTRL_NEUR_TREF),
    .CTRL_NEUR_VIRTS        (CTRL_NEUR_VIRTS),
    .NEUR_EVENT_OUT         (NEUR_EVENT_OUT),
    .NEUR_DISABLE           (NEUR_DISABLE),
    .SPK_VALID              (SPK_VALID),
    .SPK_READY              (SPK_READY),
    .SPK_DATA               (SPK_DATA),
    .SWEEP_BUSY             (SWEEP_BUSY)
  );

  always #5 CLK = ~CLK;

  // Neuron core model: event code appears only in a write-phase cycle for masked addresses.
  always_comb NEUR_EVENT_OUT = ((CTRL_NEUR_TREF || CTRL_NEUR_EVENT) && spk_mask[CTRL_NEURMEM_ADDR])
                               ? evt_code : 7'd0;
  always_comb NEUR_DISABLE = dis_en && (CTRL_NEURMEM_ADDR == dis_addr);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic start_req(input logic typ, input logic [7:0] a, input logic [4:0] v);
    REQ_TYPE  = typ;
    REQ_ADDR  = a;
    REQ_VIRTS = v;
    REQ_VALID = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
  endtask

  task automatic pop_one();
    SPK_READY = 1'b1;
    @(negedge CLK);
    SPK_READY = 1'b0;
  endtask

  task automatic test_reset();
    RSTN_syncn = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (REQ_READY !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", REQ_READY); end
    checks++;
    if ({CTRL_NEURMEM_CS, CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR, CTRL_NEUR_EVENT, CTRL_NEUR_TREF, CTRL_NEUR_VIRTS} !== 17'd0) begin
      errors++; $display("FAIL reset_ctrl: cs=%b we=%b addr=%h ev=%b tref=%b virts=%b want all 0",
        CTRL_NEURMEM_CS, CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR, CTRL_NEUR_EVENT, CTRL_NEUR_TREF, CTRL_NEUR_VIRTS);
    end
    checks++;
    if ({SPK_VALID, SPK_DATA, SWEEP_BUSY} !== 17'd0) begin
      errors++; $display("FAIL reset_spk_busy: valid=%b data=%h busy=%b want 0", SPK_VALID, SPK_DATA, SWEEP_BUSY);
    end
    RSTN_syncn = 1'b1;
    @(negedge CLK);
    checks++;
    if (REQ_READY !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", REQ_READY); end
  endtask

  task automatic test_single();
    spk_mask = '0;
    start_req(1'b0, 8'h2A, 5'b10110);
    checks++;
    if ({CTRL_NEURMEM_CS, CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR, SWEEP_BUSY, REQ_READY} !== {1'b1, 1'b0, 8'h2A, 1'b1, 1'b0}) begin
      errors++; $display("FAIL single_rd: cs=%b we=%b addr=%h busy=%b ready=%b want 1 0 2a 1 0",
        CTRL_NEURMEM_CS, CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR, SWEEP_BUSY, REQ_READY);
    end
    @(negedge CLK);
    checks++;
    if ({CTRL_NEURMEM_CS, CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR, CTRL_NEUR_EVENT, CTRL_NEUR_TREF, CTRL_NEUR_VIRTS}
        !== {1'b1, 1'b1, 8'h2A, 1'b1, 1'b0, 5'b10110}) begin
      errors++; $display("FAIL single_wr: cs=%b we=%b addr=%h ev=%b tref=%b virts=%b want 1 1 2a 1 0 10110",
        CTRL_NEURMEM_CS, CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR, CTRL_NEUR_EVENT, CTRL_NEUR_TREF, CTRL_NEUR_VIRTS);
    end
    @(negedge CLK);
    checks++;
    if ({REQ_READY, SWEEP_BUSY, SPK_VALID} !== 3'b100) begin
      errors++; $display("FAIL single_done: ready=%b busy=%b spk_valid=%b want 1 0 0", REQ_READY, SWEEP_BUSY, SPK_VALID);
    end
    // Single update that spikes: FIFO output appears in cycle t+3.
    spk_mask[5] = 1'b1;
    evt_code    = 7'h13;
    start_req(1'b0, 8'h05, 5'b00001);
    @(negedge CLK);
    checks++;
    if (SPK_VALID !== 1'b0) begin errors++; $display("FAIL single_spk_early: valid=%b want 0 in write cycle", SPK_VALID); end
    @(negedge CLK);
    checks++;
    if ({SPK_VALID, SPK_DATA} !== {1'b1, 8'h05, 7'h13}) begin
      errors++; $display("FAIL single_spk: valid=%b data=%h want 1 %h", SPK_VALID, SPK_DATA, {8'h05, 7'h13});
    end
    pop_one();
    checks++;
    if (SPK_VALID !== 1'b0) begin errors++; $display("FAIL single_pop: valid=%b want 0", SPK_VALID); end
    spk_mask = '0;
  endtask

  task automatic test_sweep();
    int busy;
    spk_mask      = '0;
    spk_mask[3]   = 1'b1;
    spk_mask[200] = 1'b1;
    evt_code      = 7'h41;
    start_req(1'b1, 8'h77, 5'h1F);
    checks++;
    if ({CTRL_NEURMEM_CS, CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR} !== {1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL sweep_first_rd: cs=%b we=%b addr=%h want 1 0 00", CTRL_NEURMEM_CS, CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR);
    end
    @(negedge CLK);
    checks++;
    if ({CTRL_NEURMEM_CS, CTRL_NEURMEM_WE, CTRL_NEUR_EVENT, CTRL_NEUR_TREF, CTRL_NEUR_VIRTS} !== {4'b1101, 5'd0}) begin
      errors++; $display("FAIL sweep_first_wr: cs=%b we=%b ev=%b tref=%b virts=%b want 1 1 0 1 00000",
        CTRL_NEURMEM_CS, CTRL_NEURMEM_WE, CTRL_NEUR_EVENT, CTRL_NEUR_TREF, CTRL_NEUR_VIRTS);
    end
    busy = 2;
    @(negedge CLK);
    while (SWEEP_BUSY && busy < 2000) begin
      busy++;
      @(negedge CLK);
    end
    checks++;
    if (busy !== 512) begin errors++; $display("FAIL sweep_busy_len: got %0d want 512", busy); end
    checks++;
    if ({SPK_VALID, SPK_DATA} !== {1'b1, 8'd3, 7'h41}) begin
      errors++; $display("FAIL sweep_spk0: valid=%b data=%h want 1 %h", SPK_VALID, SPK_DATA, {8'd3, 7'h41});
    end
    pop_one();
    checks++;
    if ({SPK_VALID, SPK_DATA} !== {1'b1, 8'd200, 7'h41}) begin
      errors++; $display("FAIL sweep_spk1: valid=%b data=%h want 1 %h", SPK_VALID, SPK_DATA, {8'd200, 7'h41});
    end
    pop_one();
    checks++;
    if (SPK_VALID !== 1'b0) begin errors++; $display("FAIL sweep_drained: valid=%b want 0", SPK_VALID); end
    spk_mask = '0;
  endtask

  task automatic test_stall();
    int n;
    int cyc;
    int first_rd;
    logic [7:0] exp_a;
    spk_mask  = '1;
    evt_code  = 7'h2C;
    SPK_READY = 1'b0;
    start_req(1'b1, 8'h00, 5'h00);
    repeat (19) @(negedge CLK);
    checks++;
    if ({CTRL_NEURMEM_CS, CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR, CTRL_NEUR_EVENT, CTRL_NEUR_TREF, CTRL_NEUR_VIRTS} !== 17'd0) begin
      errors++; $display("FAIL stall_ctrl: cs=%b we=%b addr=%h ev=%b tref=%b want all 0 while stalled",
        CTRL_NEURMEM_CS, CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR, CTRL_NEUR_EVENT, CTRL_NEUR_TREF);
    end
    checks++;
    if ({SWEEP_BUSY, SPK_VALID, SPK_DATA} !== {2'b11, 8'd0, 7'h2C}) begin
      errors++; $display("FAIL stall_state: busy=%b valid=%b data=%h want 1 1 %h", SWEEP_BUSY, SPK_VALID, SPK_DATA, {8'd0, 7'h2C});
    end
    SPK_READY = 1'b1;
    n = 0;
    cyc = 0;
    first_rd = -1;
    while ((SWEEP_BUSY || SPK_VALID) && cyc < 2000) begin
      if (SPK_VALID) begin
        exp_a = n[7:0];
        checks++;
        if (SPK_DATA !== {exp_a, 7'h2C}) begin
          errors++; $display("FAIL stall_entry_%0d: got %h want %h", n, SPK_DATA, {exp_a, 7'h2C});
        end
        n++;
      end
      if (first_rd < 0 && CTRL_NEURMEM_CS && !CTRL_NEURMEM_WE) first_rd = int'(CTRL_NEURMEM_ADDR);
      @(negedge CLK);
      cyc++;
    end
    SPK_READY = 1'b0;
    checks++;
    if (cyc >= 2000) begin errors++; $display("FAIL stall_timeout: drained after %0d cycles, want under 2000", cyc); end
    checks++;
    if (n !== 256) begin errors++; $display("FAIL stall_count: got %0d entries want 256", n); end
    checks++;
    if (first_rd !== 8) begin errors++; $display("FAIL stall_resume_addr: got %0d want 8", first_rd); end
    spk_mask = '0;
  endtask

  task automatic test_gate();
    int cyc;
    int bad;
    int last;
    spk_mask = '0;
    start_req(1'b1, 8'h00, 5'h00);
    cyc = 0;
    while (!(CTRL_NEURMEM_CS && !CTRL_NEURMEM_WE && CTRL_NEURMEM_ADDR == 8'd100) && cyc < 1000) begin
      @(negedge CLK);
      cyc++;
    end
    checks++;
    if (cyc >= 1000) begin errors++; $display("FAIL gate_reach100: not reached in %0d cycles", cyc); end
    SPI_GATE_ACTIVITY_sync = 1'b1;
    REQ_VALID = 1'b1;
    REQ_TYPE  = 1'b0;
    bad = 0;
    last = -1;
    cyc = 0;
    while (SWEEP_BUSY && cyc < 1000) begin
      if (REQ_READY !== 1'b0) bad++;
      if (CTRL_NEUR_TREF) last = int'(CTRL_NEURMEM_ADDR);
      @(negedge CLK);
      cyc++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL gate_ready_busy: ready high in %0d cycles want 0", bad); end
    checks++;
    if (last !== 255) begin errors++; $display("FAIL gate_last_addr: got %0d want 255", last); end
    @(negedge CLK);
    checks++;
    if ({REQ_READY, SWEEP_BUSY} !== 2'b00) begin
      errors++; $display("FAIL gate_blocked: ready=%b busy=%b want 0 0", REQ_READY, SWEEP_BUSY);
    end
    REQ_VALID = 1'b0;
    SPI_GATE_ACTIVITY_sync = 1'b0;
    @(negedge CLK);
    checks++;
    if (REQ_READY !== 1'b1) begin errors++; $display("FAIL gate_release: ready=%b want 1", REQ_READY); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] seen;
    logic [5:0] busy_seen;
    spk_mask       = '0;
    spk_mask[8'h30] = 1'b1;
    spk_mask[8'h31] = 1'b1;
    evt_code  = 7'h05;
    SPK_READY = 1'b0;
    REQ_TYPE  = 1'b0;
    REQ_ADDR  = 8'h30;
    REQ_VIRTS = 5'd0;
    REQ_VALID = 1'b1;
    seen = '0;
    busy_seen = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      seen[i] = REQ_READY;
      busy_seen[i] = SWEEP_BUSY;
      if (i == 2) REQ_ADDR = 8'h31;
      if (i == 4) REQ_VALID = 1'b0;
    end
    checks++;
    if (seen !== 6'b100100) begin errors++; $display("FAIL b2b_ready: got %b want 100100", seen); end
    checks++;
    if (busy_seen !== 6'b011011) begin errors++; $display("FAIL b2b_busy: got %b want 011011", busy_seen); end
    checks++;
    if ({SPK_VALID, SPK_DATA} !== {1'b1, 8'h30, 7'h05}) begin
      errors++; $display("FAIL b2b_spk0: valid=%b data=%h want 1 %h", SPK_VALID, SPK_DATA, {8'h30, 7'h05});
    end
    pop_one();
    checks++;
    if ({SPK_VALID, SPK_DATA} !== {1'b1, 8'h31, 7'h05}) begin
      errors++; $display("FAIL b2b_spk1: valid=%b data=%h want 1 %h", SPK_VALID, SPK_DATA, {8'h31, 7'h05});
    end
    pop_one();
    spk_mask = '0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    spk_mask     = '0;
    spk_mask[10] = 1'b1;
    spk_mask[20] = 1'b1;
    spk_mask[30] = 1'b1;
    evt_code  = 7'h01;
    SPK_READY = 1'b0;
    start_req(1'b1, 8'h00, 5'h00);
    cyc = 0;
    while (!(CTRL_NEURMEM_CS && !CTRL_NEURMEM_WE && CTRL_NEURMEM_ADDR == 8'd57) && cyc < 1000) begin
      @(negedge CLK);
      cyc++;
    end
    checks++;
    if ({SPK_VALID, SPK_DATA} !== {1'b1, 8'd10, 7'h01}) begin
      errors++; $display("FAIL rstmid_pre: valid=%b data=%h want 1 %h", SPK_VALID, SPK_DATA, {8'd10, 7'h01});
    end
    RSTN_syncn = 1'b0;
    @(negedge CLK);
    RSTN_syncn = 1'b1;
    #1;
    checks++;
    if ({SWEEP_BUSY, SPK_VALID, SPK_DATA} !== 17'd0) begin
      errors++; $display("FAIL rstmid_state: busy=%b valid=%b data=%h want 0", SWEEP_BUSY, SPK_VALID, SPK_DATA);
    end
    checks++;
    if ({CTRL_NEURMEM_CS, CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR, CTRL_NEUR_EVENT, CTRL_NEUR_TREF, CTRL_NEUR_VIRTS} !== 17'd0) begin
      errors++; $display("FAIL rstmid_ctrl: cs=%b we=%b addr=%h want all 0", CTRL_NEURMEM_CS, CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR);
    end
    checks++;
    if (REQ_READY !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", REQ_READY); end
    @(negedge CLK);
    spk_mask = '0;
  endtask

  task automatic test_disable();
    int busy;
    logic [1:0] wr10;
    logic [1:0] wr11;
    spk_mask     = '0;
    spk_mask[10] = 1'b1;
    spk_mask[11] = 1'b1;
    evt_code  = 7'h22;
    SPK_READY = 1'b0;
    dis_en    = 1'b1;
    dis_addr  = 8'd10;
    wr10 = 2'bxx;
    wr11 = 2'bxx;
    start_req(1'b1, 8'h00, 5'h00);
    busy = 1;
    while (SWEEP_BUSY && busy < 2000) begin
      if (CTRL_NEUR_TREF && CTRL_NEURMEM_ADDR == 8'd10) wr10 = {CTRL_NEURMEM_CS, CTRL_NEURMEM_WE};
      if (CTRL_NEUR_TREF && CTRL_NEURMEM_ADDR == 8'd11) wr11 = {CTRL_NEURMEM_CS, CTRL_NEURMEM_WE};
      @(negedge CLK);
      busy++;
    end
    busy--;
    dis_en = 1'b0;
    checks++;
    if (busy !== 512) begin errors++; $display("FAIL dis_busy_len: got %0d want 512", busy); end
    checks++;
    if (wr11 !== 2'b11) begin errors++; $display("FAIL dis_wr11: cs/we=%b want 11", wr11); end
`ifdef NEUR_SWEEP_DIS_SKIP_EN
    checks++;
    if (wr10 !== 2'b00) begin errors++; $display("FAIL dis_wr10: cs/we=%b want 00", wr10); end
`else
    checks++;
    if (wr10 !== 2'b11) begin errors++; $display("FAIL dis_wr10: cs/we=%b want 11", wr10); end
    checks++;
    if ({SPK_VALID, SPK_DATA} !== {1'b1, 8'd10, 7'h22}) begin
      errors++; $display("FAIL dis_spk10: valid=%b data=%h want 1 %h", SPK_VALID, SPK_DATA, {8'd10, 7'h22});
    end
    pop_one();
`endif
    checks++;
    if ({SPK_VALID, SPK_DATA} !== {1'b1, 8'd11, 7'h22}) begin
      errors++; $display("FAIL dis_spk11: valid=%b data=%h want 1 %h", SPK_VALID, SPK_DATA, {8'd11, 7'h22});
    end
    pop_one();
    checks++;
    if (SPK_VALID !== 1'b0) begin errors++; $display("FAIL dis_drained: valid=%b want 0", SPK_VALID); end
    spk_mask = '0;
  endtask

  initial begin
    RSTN_syncn = 1'b0;
    SPI_GATE_ACTIVITY_sync = 1'b0;
    REQ_VALID = 1'b0;
    REQ_TYPE  = 1'b0;
    REQ_ADDR  = 8'd0;
    REQ_VIRTS = 5'd0;
    SPK_READY = 1'b0;
    spk_mask  = '0;
    evt_code  = 7'd0;
    dis_en    = 1'b0;
    dis_addr  = 8'd0;
    @(negedge CLK);
    test_reset();
    test_single();
    test_sweep();
    test_stall();
    test_gate();
    test_back_to_back();
    test_reset_mid();
    test_disable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
